atax_call_sched: RTL and testbench

//  Job scheduler in front of the atax HLS component. Buffers host job descriptors
//  (tag + A/x/y/tmp pointers) and issues them on the component call interface.

---
 rtl/atax_sched_pkg.sv | 30 +++
 rtl/atax_sched_fifo.sv | 67 ++++++
 rtl/atax_call_sched.sv | 176 +++++++++++++++++
 tb/tb_atax_call_sched.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/atax_sched_pkg.sv
// Shared types and helpers for the atax call scheduler.
package atax_sched_pkg;

  localparam int unsigned DEF_PTR_W = 64;
  localparam int unsigned DEF_TAG_W = 4;

  typedef struct packed {
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_PTR_W-1:0] a;
    logic [DEF_PTR_W-1:0] x;
    logic [DEF_PTR_W-1:0] y;
    logic [DEF_PTR_W-1:0] tmp;
  } job_t;

  typedef enum logic {
    ISS_IDLE = 1'b0,
    ISS_CALL = 1'b1
  } iss_st_e;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/atax_sched_fifo.sv
// Synchronous FIFO with registered full/empty flags and next-cycle flag look-ahead.
module atax_sched_fifo
  import atax_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_c,
  output logic             full_o,
  output logic             empty_o,
  output logic             full_nxt_c,
  output logic             empty_nxt_c
);

  localparam int unsigned AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int unsigned CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  always_comb begin
    do_push     = push_i && !full_q;
    do_pop      = pop_i && !empty_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    cnt_d       = cnt_q + CW'(do_push) - CW'(do_pop);
    full_nxt_c  = (cnt_d == CW'(DEPTH));
    empty_nxt_c = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_nxt_c;
      empty_q  <= empty_nxt_c;
    end
  end

  // Storage needs no reset; the flags gate every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_c  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/atax_call_sched.sv
// Job scheduler in front of the atax HLS component: queues host jobs, issues calls,
// bounds outstanding calls and returns tagged completions in issue order.
module atax_call_sched
  import atax_sched_pkg::*;
#(
  parameter int unsigned PTR_W        = DEF_PTR_W,
  parameter int unsigned QDEPTH       = 4,
  parameter int unsigned MAX_INFLIGHT = 2,
  parameter int unsigned TAG_W        = DEF_TAG_W
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             enable,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [TAG_W-1:0] job_tag,
  input  logic [PTR_W-1:0] job_A,
  input  logic [PTR_W-1:0] job_x,
  input  logic [PTR_W-1:0] job_y,
  input  logic [PTR_W-1:0] job_tmp,
  output logic             cpl_valid,
  input  logic             cpl_ready,
  output logic [TAG_W-1:0] cpl_tag,
  output logic [31:0]      cpl_count,
  output logic             idle,
  output logic             err,
  output logic             k_start,
  input  logic             k_busy,
  input  logic             k_done,
  output logic             k_stall,
  output logic [PTR_W-1:0] k_A,
  output logic [PTR_W-1:0] k_x,
  output logic [PTR_W-1:0] k_y,
  output logic [PTR_W-1:0] k_tmp
);

  localparam int unsigned IW = clog2(MAX_INFLIGHT + 1);

  iss_st_e          st_q, st_d;
  job_t             q_wdata, q_head;
  logic             q_full, q_empty, q_full_nxt, q_empty_nxt;
  logic [TAG_W-1:0] tag_head;
  logic             tag_full, tag_empty, tag_full_nxt, tag_empty_nxt;
  logic             unused_c;

  logic [IW-1:0]    inflight_q, inflight_d;
  logic [PTR_W-1:0] k_A_q, k_A_d, k_x_q, k_x_d, k_y_q, k_y_d, k_tmp_q, k_tmp_d;
  logic             cpl_valid_q, cpl_valid_d;
  logic [TAG_W-1:0] cpl_tag_q, cpl_tag_d;
  logic [31:0]      cpl_count_q, cpl_count_d;
  logic             err_q, err_d;
  logic             job_ready_q, job_ready_d;
  logic             idle_q, idle_d;

  logic             push_c, accept_c, issue_ok_c, ret_ok_c, spurious_c;

  always_comb begin
    q_wdata.tag = DEF_TAG_W'(job_tag);
    q_wdata.a   = DEF_PTR_W'(job_A);
    q_wdata.x   = DEF_PTR_W'(job_x);
    q_wdata.y   = DEF_PTR_W'(job_y);
    q_wdata.tmp = DEF_PTR_W'(job_tmp);
  end

  assign push_c     = job_valid && job_ready_q;
  assign accept_c   = (st_q == ISS_CALL) && !k_busy;
  assign issue_ok_c = !q_empty && enable && (inflight_q < IW'(MAX_INFLIGHT));
  assign k_stall    = cpl_valid_q && !cpl_ready;
  assign ret_ok_c   = k_done && !k_stall && (inflight_q != '0);
  assign spurious_c = k_done && (inflight_q == '0);

  atax_sched_fifo #(.WIDTH($bits(job_t)), .DEPTH(QDEPTH)) u_job_q (
    .clk        (clock),
    .rst_n      (resetn),
    .push_i     (push_c),
    .pop_i      (accept_c),
    .wdata_i    (q_wdata),
    .head_c     (q_head),
    .full_o     (q_full),
    .empty_o    (q_empty),
    .full_nxt_c (q_full_nxt),
    .empty_nxt_c(q_empty_nxt)
  );

  atax_sched_fifo #(.WIDTH(TAG_W), .DEPTH(MAX_INFLIGHT)) u_tag_q (
    .clk        (clock),
    .rst_n      (resetn),
    .push_i     (accept_c),
    .pop_i      (ret_ok_c),
    .wdata_i    (TAG_W'(q_head.tag)),
    .head_c     (tag_head),
    .full_o     (tag_full),
    .empty_o    (tag_empty),
    .full_nxt_c (tag_full_nxt),
    .empty_nxt_c(tag_empty_nxt)
  );

  assign unused_c = ^{q_full, tag_full, tag_empty, tag_full_nxt, tag_empty_nxt};

  // Issue FSM state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) st_q <= ISS_IDLE;
    else         st_q <= st_d;
  end

  // Once raised, a call is held until atax accepts it, regardless of enable.
  always_comb begin
    st_d = st_q;
    case (st_q)
      ISS_IDLE: if (issue_ok_c) st_d = ISS_CALL;
      ISS_CALL: if (!k_busy)    st_d = ISS_IDLE;
      default:                  st_d = ISS_IDLE;
    endcase
  end

  always_comb begin
    k_A_d       = k_A_q;
    k_x_d       = k_x_q;
    k_y_d       = k_y_q;
    k_tmp_d     = k_tmp_q;
    if ((st_q == ISS_IDLE) && issue_ok_c) begin
      k_A_d   = PTR_W'(q_head.a);
      k_x_d   = PTR_W'(q_head.x);
      k_y_d   = PTR_W'(q_head.y);
      k_tmp_d = PTR_W'(q_head.tmp);
    end
    inflight_d  = inflight_q + IW'(accept_c) - IW'(ret_ok_c);
    cpl_valid_d = ret_ok_c ? 1'b1 : (cpl_ready ? 1'b0 : cpl_valid_q);
    cpl_tag_d   = ret_ok_c ? tag_head : cpl_tag_q;
    cpl_count_d = cpl_count_q + 32'(ret_ok_c);
    err_d       = err_q || spurious_c;
    job_ready_d = !q_full_nxt;
    idle_d      = q_empty_nxt && (inflight_d == '0) && !cpl_valid_d && (st_d == ISS_IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      k_A_q       <= '0;
      k_x_q       <= '0;
      k_y_q       <= '0;
      k_tmp_q     <= '0;
      inflight_q  <= '0;
      cpl_valid_q <= 1'b0;
      cpl_tag_q   <= '0;
      cpl_count_q <= '0;
      err_q       <= 1'b0;
      job_ready_q <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      k_A_q       <= k_A_d;
      k_x_q       <= k_x_d;
      k_y_q       <= k_y_d;
      k_tmp_q     <= k_tmp_d;
      inflight_q  <= inflight_d;
      cpl_valid_q <= cpl_valid_d;
      cpl_tag_q   <= cpl_tag_d;
      cpl_count_q <= cpl_count_d;
      err_q       <= err_d;
      job_ready_q <= job_ready_d;
      idle_q      <= idle_d;
    end
  end

  assign k_start   = (st_q == ISS_CALL);
  assign k_A       = k_A_q;
  assign k_x       = k_x_q;
  assign k_y       = k_y_q;
  assign k_tmp     = k_tmp_q;
  assign cpl_valid = cpl_valid_q;
  assign cpl_tag   = cpl_tag_q;
  assign cpl_count = cpl_count_q;
  assign err       = err_q;
  assign job_ready = job_ready_q;
  assign idle      = idle_q;

endmodule

// File: tb/tb_atax_call_sched.sv
// Directed bench for atax_call_sched: issue/accept, back-pressure, in-order completions, reset.
module tb_atax_call_sched;

  logic        clock = 1'b0;
  logic        resetn, enable, job_valid, cpl_ready, k_busy, k_done;
  logic        job_ready, cpl_valid, idle, err, k_start, k_stall;
  logic [3:0]  job_tag, cpl_tag;
  logic [63:0] job_A, job_x, job_y, job_tmp, k_A, k_x, k_y, k_tmp;
  logic [31:0] cpl_count;

  int          n_vec = 0;
  int          n_mis = 0;
  int          acc_cnt = 0;
  int          done_cnt = 0;
  int          kst_cyc = 0;
  logic [63:0] acc_a[$];
  logic [3:0]  cpl_log[$];
  logic [31:0] exp_cnt;

  always #5 clock = ~clock;

  atax_call_sched dut (
    .clock(clock), .resetn(resetn), .enable(enable),
    .job_valid(job_valid), .job_ready(job_ready), .job_tag(job_tag),
    .job_A(job_A), .job_x(job_x), .job_y(job_y), .job_tmp(job_tmp),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_tag(cpl_tag),
    .cpl_count(cpl_count), .idle(idle), .err(err),
    .k_start(k_start), .k_busy(k_busy), .k_done(k_done), .k_stall(k_stall),
    .k_A(k_A), .k_x(k_x), .k_y(k_y), .k_tmp(k_tmp)
  );

  // Observe accepted calls, k_start occupancy and delivered completions.
  always @(posedge clock) begin
    if (resetn) begin
      if (k_start) kst_cyc++;
      if (k_start && !k_busy) begin
        acc_cnt++;
        acc_a.push_back(k_A);
      end
      if (cpl_valid && cpl_ready) cpl_log.push_back(cpl_tag);
    end
  end

  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", t, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic push_job(input logic [3:0] t, input logic [63:0] a);
    int w = 0;
    while (!job_ready && w < 50) begin
      tick();
      w++;
    end
    chk("push_wait_timeout", 64'(w >= 50), 64'd0);
    job_tag = t; job_A = a; job_x = a + 64'd1; job_y = a + 64'd2; job_tmp = a + 64'd3;
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
  endtask

  // Answer every accepted call with a done until n completions are delivered.
  task automatic serve(input int n, input int budget);
    int w = 0;
    while (cpl_log.size() < n && w < budget) begin
      if (acc_cnt > done_cnt) begin
        k_done = 1'b1;
        done_cnt++;
      end else begin
        k_done = 1'b0;
      end
      tick();
      w++;
    end
    k_done = 1'b0;
    chk("serve_timeout", 64'(w >= budget), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, k0, w;
    resetn = 1'b0; enable = 1'b0; job_valid = 1'b0; cpl_ready = 1'b0;
    k_busy = 1'b0; k_done = 1'b0; job_tag = '0;
    job_A = '0; job_x = '0; job_y = '0; job_tmp = '0;
    repeat (3) tick();
    chk("rst_job_ready", 64'(job_ready), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_k_start", 64'(k_start), 64'd0);
    chk("rst_cpl_valid", 64'(cpl_valid), 64'd0);
    chk("rst_k_stall", 64'(k_stall), 64'd0);
    chk("rst_cpl_count", 64'(cpl_count), 64'd0);
    resetn = 1'b1;
    tick();
    chk("rel_job_ready", 64'(job_ready), 64'd1);

    // 1: single job, completion five cycles later
    enable = 1'b1; cpl_ready = 1'b1; k_busy = 1'b0;
    k0 = kst_cyc;
    push_job(4'd3, 64'h1000);
    chk("t1_idle_busy", 64'(idle), 64'd0);
    chk("t1_no_bypass", 64'(k_start), 64'd0);
    tick();
    chk("t1_k_start", 64'(k_start), 64'd1);
    chk("t1_k_A", k_A, 64'h1000);
    chk("t1_k_tmp", k_tmp, 64'h1003);
    tick();
    chk("t1_k_start_drop", 64'(k_start), 64'd0);
    repeat (3) tick();
    k_done = 1'b1; done_cnt++;
    tick();
    k_done = 1'b0;
    chk("t1_cpl_valid", 64'(cpl_valid), 64'd1);
    chk("t1_cpl_tag", 64'(cpl_tag), 64'd3);
    chk("t1_cpl_count", 64'(cpl_count), 64'd1);
    tick();
    chk("t1_cpl_clear", 64'(cpl_valid), 64'd0);
    chk("t1_idle", 64'(idle), 64'd1);
    chk("t1_kstart_cycles", 64'(kst_cyc - k0), 64'd1);
    exp_cnt = 32'd1;

    // 2: fill the queue while disabled, then drain in order
    enable = 1'b0; cpl_log.delete(); acc_a.delete();
    for (int i = 1; i <= 4; i++) begin
      push_job(4'(i), 64'(i) * 64'h100);
      chk("t2_job_ready", 64'(job_ready), 64'(i < 4));
    end
    chk("t2_no_issue", 64'(k_start), 64'd0);
    enable = 1'b1;
    push_job(4'd5, 64'h500);
    serve(5, 200);
    chk("t2_cpl_n", 64'(cpl_log.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < cpl_log.size()) chk("t2_cpl_tag_order", 64'(cpl_log[i]), 64'(i + 1));
      if (i < acc_a.size())   chk("t2_issue_order", acc_a[i], 64'(i + 1) * 64'h100);
    end
    exp_cnt = exp_cnt + 32'd5;
    chk("t2_cpl_count", 64'(cpl_count), 64'(exp_cnt));
    chk("t2_idle", 64'(idle), 64'd1);

    // 3: call held under k_busy, enable toggling, single accept
    k_busy = 1'b1; enable = 1'b1; cpl_log.delete(); a0 = acc_cnt;
    push_job(4'd7, 64'h7000);
    w = 0;
    while (!k_start && w < 10) begin tick(); w++; end
    chk("t3_start_timeout", 64'(w >= 10), 64'd0);
    for (int i = 0; i < 10; i++) begin
      enable = i[0];
      tick();
      chk("t3_hold_start", 64'(k_start), 64'd1);
      chk("t3_hold_A", k_A, 64'h7000);
      chk("t3_hold_y", k_y, 64'h7002);
    end
    chk("t3_no_accept", 64'(acc_cnt - a0), 64'd0);
    k_busy = 1'b0; enable = 1'b1;
    tick();
    chk("t3_one_accept", 64'(acc_cnt - a0), 64'd1);
    chk("t3_start_drop", 64'(k_start), 64'd0);
    repeat (3) tick();
    chk("t3_still_one", 64'(acc_cnt - a0), 64'd1);
    serve(1, 50);
    if (cpl_log.size() > 0) chk("t3_cpl_tag", 64'(cpl_log[0]), 64'd7);
    exp_cnt = exp_cnt + 32'd1;

    // 4: at most two calls outstanding
    cpl_log.delete(); a0 = acc_cnt;
    push_job(4'd8, 64'h800);
    push_job(4'd9, 64'h900);
    push_job(4'd10, 64'hA00);
    repeat (20) tick();
    chk("t4_two_accepts", 64'(acc_cnt - a0), 64'd2);
    chk("t4_no_start", 64'(k_start), 64'd0);
    k_done = 1'b1; done_cnt++;
    tick();
    k_done = 1'b0;
    w = 0;
    while ((acc_cnt - a0) < 3 && w < 10) begin tick(); w++; end
    chk("t4_third_accept", 64'(acc_cnt - a0), 64'd3);
    serve(3, 100);
    for (int i = 0; i < 3; i++)
      if (i < cpl_log.size()) chk("t4_cpl_tag_order", 64'(cpl_log[i]), 64'(i + 8));
    exp_cnt = exp_cnt + 32'd3;
    chk("t4_cpl_count", 64'(cpl_count), 64'(exp_cnt));

    // 5: completion back-pressure stalls the second return
    cpl_ready = 1'b0; cpl_log.delete();
    push_job(4'd11, 64'hB00);
    push_job(4'd12, 64'hC00);
    w = 0;
    while ((acc_cnt - done_cnt) < 2 && w < 20) begin tick(); w++; end
    chk("t5_two_out", 64'(acc_cnt - done_cnt), 64'd2);
    k_done = 1'b1; done_cnt++;
    tick();
    chk("t5_k_stall", 64'(k_stall), 64'd1);
    chk("t5_first_tag", 64'(cpl_tag), 64'd11);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_hold_tag", 64'(cpl_tag), 64'd11);
      chk("t5_hold_count", 64'(cpl_count), 64'(exp_cnt + 32'd1));
    end
    chk("t5_not_taken", 64'(cpl_log.size()), 64'd0);
    cpl_ready = 1'b1;
    #1;
    chk("t5_unstall", 64'(k_stall), 64'd0);
    tick();
    done_cnt++; k_done = 1'b0;
    chk("t5_second_valid", 64'(cpl_valid), 64'd1);
    chk("t5_second_tag", 64'(cpl_tag), 64'd12);
    chk("t5_count2", 64'(cpl_count), 64'(exp_cnt + 32'd2));
    tick();
    chk("t5_cpl_clear", 64'(cpl_valid), 64'd0);
    chk("t5_log_n", 64'(cpl_log.size()), 64'd2);
    if (cpl_log.size() == 2) begin
      chk("t5_log0", 64'(cpl_log[0]), 64'd11);
      chk("t5_log1", 64'(cpl_log[1]), 64'd12);
    end
    exp_cnt = exp_cnt + 32'd2;

    // 6a: done with nothing in flight
    chk("t6_err_clean", 64'(err), 64'd0);
    k_done = 1'b1;
    tick();
    k_done = 1'b0;
    chk("t6_err_set", 64'(err), 64'd1);
    chk("t6_no_cpl", 64'(cpl_valid), 64'd0);
    chk("t6_count_same", 64'(cpl_count), 64'(exp_cnt));
    repeat (3) tick();
    chk("t6_err_sticky", 64'(err), 64'd1);

    // 6b: reset with jobs queued
    enable = 1'b0;
    push_job(4'd1, 64'h10);
    push_job(4'd2, 64'h20);
    push_job(4'd3, 64'h30);
    chk("t6_busy_idle", 64'(idle), 64'd0);
    resetn = 1'b0;
    #1;
    chk("t6_rst_job_ready", 64'(job_ready), 64'd0);
    chk("t6_rst_idle", 64'(idle), 64'd1);
    chk("t6_rst_err", 64'(err), 64'd0);
    chk("t6_rst_count", 64'(cpl_count), 64'd0);
    chk("t6_rst_k_start", 64'(k_start), 64'd0);
    chk("t6_rst_k_A", k_A, 64'd0);
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    chk("t6_rel_job_ready", 64'(job_ready), 64'd1);
    enable = 1'b1;
    repeat (5) tick();
    chk("t6_queue_gone", 64'(k_start), 64'd0);
    chk("t6_idle_after", 64'(idle), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
